// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg
// Shared definitions for the truth-table sweeper: sweep FSM states and the
// dimensions of the stimulus vector and of the captured truth tables.
package tt_sweep_pkg;

  localparam int N_VEC  = 16;  // number of input combinations swept
  localparam int N_FUNC = 8;   // number of function outputs captured
  localparam int VEC_W  = 4;   // width of the {A,B,C,D} stimulus vector

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } sweepState_t;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if
// Groups the sweeper's control, stimulus, capture and readback signals.
//   start    : request a sweep
//   abcd     : stimulus to the combinational functions (abcd[3]=A .. abcd[0]=D)
//   y_in     : function outputs (y_in[0]=Y1 .. y_in[7]=Y8)
//   busy     : sweep in progress
//   done     : one-cycle completion pulse
//   tt_valid : tables hold a complete sweep
//   tt_sel   : readback selector for one function's table
//   tt_word  : truth table of the selected function
// Modport master is the sweeper itself; slave is the surrounding logic.
interface truth_table_sweeper_if;
  import tt_sweep_pkg::*;

  logic                start;
  logic [VEC_W-1:0]    abcd;
  logic [N_FUNC-1:0]   y_in;
  logic                busy;
  logic                done;
  logic                tt_valid;
  logic [2:0]          tt_sel;
  logic [N_VEC-1:0]    tt_word;

  modport master (
    input  start, y_in, tt_sel,
    output abcd, busy, done, tt_valid, tt_word
  );

  modport slave (
    output start, y_in, tt_sel,
    input  abcd, busy, done, tt_valid, tt_word
  );

endinterface

// File: rtl/tt_store.sv
// tt_store
// 8 x 16 flop array holding one truth-table word per function output.
//   clk, rst_n : clock and asynchronous active-low clear of every bit
//   wr_en      : capture strobe
//   wr_idx     : vector index whose column is written
//   wr_bits    : one bit per function, written to column wr_idx
//   tt_sel     : selects the function whose word is read
//   tt_word    : combinational read of the selected word
module tt_store
  import tt_sweep_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [VEC_W-1:0]   wr_idx,
  input  logic [N_FUNC-1:0]  wr_bits,
  input  logic [2:0]         tt_sel,
  output logic [N_VEC-1:0]   tt_word
);

  logic [N_FUNC-1:0][N_VEC-1:0] ttMem;

  // A capture writes the same column of all eight words at once, so each
  // function's bit for the current vector lands in its own word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ttMem <= '0;
    end else if (wr_en) begin
      for (int j = 0; j < N_FUNC; j++) begin
        ttMem[j][wr_idx] <= wr_bits[j];
      end
    end
  end

  assign tt_word = ttMem[tt_sel];

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Drives {A,B,C,D} through all 16 combinations, holds each for SETTLE+1
// cycles and captures Y1..Y8 on the final edge, building one 16-bit truth
// table per function output.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : master modport of truth_table_sweeper_if (start, abcd,
//                y_in, busy, done, tt_valid, tt_sel, tt_word)
// Parameter SETTLE (1..15): cycles each vector is held before sampling.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_sweeper_if.master  bus
);

  localparam logic [VEC_W-1:0] SETTLE_LAST = VEC_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(N_VEC - 1);

  sweepState_t       state, stateNext;
  logic [VEC_W-1:0]  vec, vecNext;
  logic [VEC_W-1:0]  settleCnt, settleCntNext;
  logic              ttValid, ttValidNext;
  logic              wrEn;

  // State register plus the vector, settle counter and validity flag that
  // travel with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      settleCnt <= '0;
      ttValid   <= 1'b0;
    end else begin
      state     <= stateNext;
      vec       <= vecNext;
      settleCnt <= settleCntNext;
      ttValid   <= ttValidNext;
    end
  end

  // Next-state logic. DRIVE lasts SETTLE cycles and SAMPLE one more, so a
  // vector is held SETTLE+1 cycles and captured on the edge leaving SAMPLE.
  // tt_valid drops when a sweep starts and rises on the edge entering DONE.
  always_comb begin
    stateNext     = state;
    vecNext       = vec;
    settleCntNext = settleCnt;
    ttValidNext   = ttValid;
    wrEn          = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          stateNext     = DRIVE;
          vecNext       = '0;
          settleCntNext = '0;
          ttValidNext   = 1'b0;
        end
      end
      DRIVE: begin
        settleCntNext = settleCnt + VEC_W'(1);
        if (settleCnt == SETTLE_LAST) begin
          stateNext = SAMPLE;
        end
      end
      SAMPLE: begin
        wrEn = 1'b1;
        if (vec == VEC_LAST) begin
          stateNext   = DONE;
          ttValidNext = 1'b1;
        end else begin
          stateNext     = DRIVE;
          vecNext       = vec + VEC_W'(1);
          settleCntNext = '0;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Stimulus is only presented while sweeping; it rests at zero otherwise.
  always_comb begin
    bus.busy     = (state == DRIVE) || (state == SAMPLE);
    bus.done     = (state == DONE);
    bus.tt_valid = ttValid;
    bus.abcd     = bus.busy ? vec : '0;
  end

  tt_store uStore (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wrEn),
    .wr_idx  (vec),
    .wr_bits (bus.y_in),
    .tt_sel  (bus.tt_sel),
    .tt_word (bus.tt_word)
  );

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
// Bench for truth_table_sweeper. Two instances share start/tt_sel: the main
// one with SETTLE=2 and a fast one with SETTLE=1. Each instance's y_in is a
// model of the combinational functions evaluated on its own abcd.
module tb_truth_table_sweeper;

  typedef logic [7:0][15:0] ttImage_t;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] expWord;
  } identityVec_t;

  localparam int SETTLE_MAIN = 2;
  localparam int SWEEP_EDGES = 16 * (SETTLE_MAIN + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       startDrive;
  logic [2:0] selDrive;
  int         mode;
  int         checks = 0;
  int         errors = 0;
  ttImage_t   sbQueue[$];

  always #10 clk = ~clk;

  truth_table_sweeper_if mIf();
  truth_table_sweeper_if fIf();

  // Model of the combinational exercise functions for each stimulus mode.
  function automatic logic [7:0] yModel(input int m, input logic [3:0] v);
    logic [7:0] y;
    case (m)
      0:       y = {5'b0, ~^v, (~v[2]) | v[1], ~v[2]};
      1:       y = {v[3], 7'b0};
      2:       y = {~v[3], 7'b0};
      default: y = {v[0] ^ v[3], v[3:1], ~v};
    endcase
    return y;
  endfunction

  // Full set of truth tables a complete sweep under mode m must produce.
  function automatic ttImage_t expectImage(input int m);
    ttImage_t img;
    logic [7:0] y;
    for (int v = 0; v < 16; v++) begin
      y = yModel(m, 4'(v));
      for (int j = 0; j < 8; j++) begin
        img[j][v] = y[j];
      end
    end
    return img;
  endfunction

  assign mIf.start  = startDrive;
  assign fIf.start  = startDrive;
  assign mIf.tt_sel = selDrive;
  assign fIf.tt_sel = selDrive;
  assign mIf.y_in   = yModel(mode, mIf.abcd);
  assign fIf.y_in   = yModel(mode, fIf.abcd);

  truth_table_sweeper #(.SETTLE(SETTLE_MAIN)) dutMain (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mIf)
  );

  truth_table_sweeper #(.SETTLE(1)) dutFast (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fIf)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge after
  // the edge that samples start (edge 0). Pushes the expected tables.
  task automatic applyStimulus(input int m, input bit holdStart);
    mode = m;
    sbQueue.push_back(expectImage(m));
    startDrive = 1'b1;
    @(negedge clk);
    if (!holdStart) startDrive = 1'b0;
  endtask

  // Pops the expected image and compares every word of the main instance.
  task automatic checkTables();
    ttImage_t img;
    checkOutput("tt_valid at done", {15'b0, mIf.tt_valid}, 16'h0001);
    if (sbQueue.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard empty: got 0 entries, expected 1");
    end else begin
      img = sbQueue.pop_front();
      for (int j = 0; j < 8; j++) begin
        selDrive = 3'(j);
        #1;
        checkOutput($sformatf("tt_word[%0d]", j), mIf.tt_word, img[j]);
      end
    end
  endtask

  task automatic waitDone(input bit fast, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((fast ? fIf.done : mIf.done) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done timeout: got no done in %0d cycles, expected done", budget);
    end
  endtask

  // Cycle-accurate sweep on the main instance; e counts negedges after edge e.
  task automatic timedSweep(input int m, input bit repulse);
    applyStimulus(m, 1'b0);
    for (int e = 0; e <= SWEEP_EDGES + 1; e++) begin
      if (e > 0) @(negedge clk);
      checkOutput($sformatf("busy e%0d", e), {15'b0, mIf.busy},
                  {15'b0, (e < SWEEP_EDGES)});
      checkOutput($sformatf("done e%0d", e), {15'b0, mIf.done},
                  {15'b0, (e == SWEEP_EDGES)});
      checkOutput($sformatf("abcd e%0d", e), {12'b0, mIf.abcd},
                  (e < SWEEP_EDGES) ? 16'(e / (SETTLE_MAIN + 1)) : 16'h0000);
      if (e == SWEEP_EDGES) checkTables();
      if (repulse && e == 10) startDrive = 1'b1;
      if (repulse && e == 11) startDrive = 1'b0;
    end
  endtask

  initial begin
    identityVec_t idTable[8];
    bit seen;

    idTable[0] = '{3'd0, 16'h0F0F};
    idTable[1] = '{3'd1, 16'hCFCF};
    idTable[2] = '{3'd2, 16'h9669};
    idTable[3] = '{3'd3, 16'h0000};
    idTable[4] = '{3'd4, 16'h0000};
    idTable[5] = '{3'd5, 16'h0000};
    idTable[6] = '{3'd6, 16'h0000};
    idTable[7] = '{3'd7, 16'h0000};

    startDrive = 1'b0;
    selDrive   = 3'd0;
    mode       = 0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("reset busy", {15'b0, mIf.busy}, 16'h0000);
    checkOutput("reset done", {15'b0, mIf.done}, 16'h0000);
    checkOutput("reset tt_valid", {15'b0, mIf.tt_valid}, 16'h0000);
    checkOutput("reset abcd", {12'b0, mIf.abcd}, 16'h0000);
    for (int j = 0; j < 8; j++) begin
      selDrive = 3'(j);
      #1;
      checkOutput($sformatf("reset tt_word[%0d]", j), mIf.tt_word, 16'h0000);
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] identity/parity sweep");
    applyStimulus(0, 1'b0);
    waitDone(1'b1, 40, seen);
    for (int i = 0; i < 8; i++) begin
      selDrive = idTable[i].sel;
      #1;
      checkOutput($sformatf("fast identity sel%0d", idTable[i].sel),
                  fIf.tt_word, idTable[i].expWord);
    end
    waitDone(1'b0, 40, seen);
    if (seen) checkTables();
    @(negedge clk);

    $display("[TB] cycle timing sweep");
    timedSweep(3, 1'b0);

    $display("[TB] ignored start sweep");
    timedSweep(3, 1'b1);

    $display("[TB] reset mid-sweep");
    applyStimulus(3, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst abcd", {12'b0, mIf.abcd}, 16'h0000);
    checkOutput("rst busy", {15'b0, mIf.busy}, 16'h0000);
    checkOutput("rst tt_valid", {15'b0, mIf.tt_valid}, 16'h0000);
    for (int j = 0; j < 8; j++) begin
      selDrive = 3'(j);
      #1;
      checkOutput($sformatf("rst tt_word[%0d]", j), mIf.tt_word, 16'h0000);
    end
    sbQueue.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b0);
    waitDone(1'b0, 60, seen);
    if (seen) checkTables();
    @(negedge clk);

    $display("[TB] back-to-back sweeps");
    applyStimulus(1, 1'b1);
    waitDone(1'b0, 60, seen);
    if (seen) checkTables();
    mode = 2;
    sbQueue.push_back(expectImage(2));
    repeat (3) @(negedge clk);
    checkOutput("b2b busy", {15'b0, mIf.busy}, 16'h0001);
    checkOutput("b2b tt_valid", {15'b0, mIf.tt_valid}, 16'h0000);
    waitDone(1'b0, 60, seen);
    if (seen) checkTables();
    startDrive = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by 200000 ns, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- **Function:** sequencer that drives the 4-bit input vector {A,B,C,D} of the lab's combinational exercise functions through all 16 combinations.
- **Capture:** after a programmable settle time it samples the eight function outputs Y1..Y8 and assembles one 16-bit truth-table word per output.
- **Position:** directly upstream of the combinational functions (it feeds them) and downstream of them (it consumes Y1..Y8).
- **Use:** the result feeds readback, display or self-check logic.

## Interface

Parameters:
- SETTLE, 1, cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request a sweep; honoured only in IDLE.
- abcd  output  4  stimulus to the functions: abcd[3]=A, abcd[2]=B, abcd[1]=C, abcd[0]=D.
- y_in  input  8  function outputs: y_in[0]=Y1 … y_in[7]=Y8.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- tt_valid  output  1  truth tables hold a complete sweep.
- tt_sel  input  3  selects output j (0→Y1 … 7→Y8) for readback.
- tt_word  output  16  truth table of selected output: bit v = Y(j+1) at abcd=v; combinational read.

## Operation

- **FSM states:** IDLE, DRIVE, SAMPLE, DONE.
- **IDLE:**
  - start=1 → DRIVE.
  - On that edge: vec=0, settle counter=0, busy=1, tt_valid=0.
- **DRIVE:**
  - abcd=vec.
  - Counter increments each cycle.
  - When the counter reaches SETTLE-1 → SAMPLE.
- **SAMPLE:**
  - On the exit edge, tt[j][vec] ← y_in[j] for all j.
  - If vec=15 → DONE.
  - Otherwise vec+1, counter=0 → DRIVE.
- **DONE:**
  - done=1 for exactly this cycle; busy=0; tt_valid=1.
  - Unconditionally → IDLE.
- **start handling:** start is ignored in DRIVE, SAMPLE and DONE. No queuing.
- **Table memory:** no clearing at sweep start; every bit is overwritten during the sweep. tt_valid is the sole freshness indicator.
- **vec width:** vec is 4 bits, and the wrap 15→0 never occurs inside a sweep. abcd holds 0 in IDLE/DONE.
- **Readback:** tt_sel may change at any time. tt_word follows it combinationally, including mid-sweep, when it shows partial data.

## Timing

- **Reset values:**
  - abcd=0, busy=0, done=0, tt_valid=0.
  - All 128 table bits =0.
  - state=IDLE.
- **Start:** let edge 0 be the edge that samples start=1 in IDLE.
- **Per-vector timing:**
  - Vector k is driven from edge k·(SETTLE+1) through edge (k+1)·(SETTLE+1).
  - Its capture occurs on edge (k+1)·(SETTLE+1).
  - Held for SETTLE+1 cycles, with sampling on the final edge.
- **End of sweep:**
  - done is high during the cycle after edge 16·(SETTLE+1), and busy falls on that edge.
  - tt_valid rises on the edge that enters DONE.
  - Total: 16·(SETTLE+1)+1 cycles from start to return to IDLE.
- **start held high:** a new sweep begins on the edge after DONE, i.e. the first IDLE cycle.
- **rst_n low mid-sweep:**
  - Immediate asynchronous return to reset values; partial table discarded.
  - Release needs no resynchronisation; rst_n is externally synchronised on deassertion.
- **Input timing:** y_in is assumed to be a pure combinational function of abcd within SETTLE cycles. No input registering beyond the capture flops.

## Structure

- **Shared package tt_sweep_pkg:**
  - State enum (IDLE, DRIVE, SAMPLE, DONE).
  - N_VEC=16, N_FUNC=8, VEC_W=4.
- **Sub-module tt_store:**
  - 8×16 flop array.
  - Write port: wr_en, wr_idx[3:0], wr_bits[7:0].
  - Read port: tt_sel → tt_word.
  - Asynchronous active-low clear.
- **Top level:** FSM and settle counter.

## Test plan

- **Identity/parity:** y_in[0]=~abcd[2], y_in[1]=~abcd[2]|abcd[1], y_in[2]=XNOR of all four bits, others 0; SETTLE=1, start pulse.
  - Required: tt_sel=0 → 0x0F0F, tt_sel=1 → 0xCFCF, tt_sel=2 → 0x9669, tt_sel=3..7 → 0x0000.
- **Cycle timing:** SETTLE=2.
  - Required: busy high edges 0..48, done pulse after edge 48, abcd=5 held for edges 15..17.
  - Required: abcd=0 after DONE.
- **Ignored start:** start re-pulsed at cycle 10 mid-sweep.
  - Required: no restart, done still at 16·(SETTLE+1), tables unchanged vs. clean run.
- **Reset mid-sweep:** rst_n low at cycle 20.
  - Required: same cycle abcd=0, busy=0, tt_valid=0, all tt_word=0x0000.
  - Required: a new start yields correct tables.
- **Back-to-back sweeps:** start held high; y_in[7]=abcd[3] in sweep 1, then y_in[7]=~abcd[3] in sweep 2.
  - Required: tt_sel=7 reads 0xFF00 after first done, 0x00FF after second.
  - Required: tt_valid low between starts.
